// File: rtl/thumb_shift_decode.sv
// Issue stage for the shift/move execute unit. Decodes Thumb-16 shift/move
// encodings, reads operands from r0-r7 and sequences one execute pulse and
// one writeback strobe per accepted instruction.
module thumb_shift_decode #(
  parameter int unsigned RF_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [15:0] inst,
  output logic        inst_ready,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic        en_inst,
  output logic        S,
  output logic [31:0] Rm,
  output logic [7:0]  operand2,
  output logic [1:0]  stype,
  output logic        wb_we,
  output logic [2:0]  wb_addr,
  output logic        undef
);

  typedef enum logic [2:0] {StIdle, StRead, StLatch, StExec, StWb} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  // Fields captured at accept time
  logic [1:0]  stype_q;
  logic [7:0]  imm_q;
  logic [2:0]  rd_q;
  logic [2:0]  ra_q;
  logic [2:0]  rb_q;
  logic        rm_imm_q;   // Rm comes from imm_q (MOVS)
  logic        op2_reg_q;  // operand2 comes from rf_rdata_b (register shifts)

  // Registered outputs to the execute unit
  logic [31:0] rm_q;
  logic [7:0]  op2_q;
  logic [1:0]  stype_out_q;
  logic        s_q;
  logic [2:0]  wb_addr_q;
  logic        undef_q;

  // Decode results
  logic        dec_ok;
  logic [1:0]  dec_stype;
  logic [7:0]  dec_imm;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_ra;
  logic [2:0]  dec_rb;
  logic        dec_rm_imm;
  logic        dec_op2_reg;

  logic        accept;
  logic        unused_rdata_b;

  assign unused_rdata_b = ^rf_rdata_b[31:8];

  // Combinational decode of the offered instruction word
  always_comb begin
    dec_ok      = 1'b0;
    dec_stype   = 2'b00;
    dec_imm     = 8'h00;
    dec_rd      = 3'd0;
    dec_ra      = 3'd0;
    dec_rb      = 3'd0;
    dec_rm_imm  = 1'b0;
    dec_op2_reg = 1'b0;
    if (inst[15:13] == 3'b000 && inst[12:11] != 2'b11) begin
      // Shift by immediate; LSR/ASR encode a shift of 32 as imm5 == 0
      dec_ok    = 1'b1;
      dec_stype = inst[12:11];
      dec_imm   = {3'b000, inst[10:6]};
      if (inst[12:11] != 2'b00 && inst[10:6] == 5'd0) begin
        dec_imm = 8'd32;
      end
      dec_ra = inst[5:3];
      dec_rd = inst[2:0];
    end else if (inst[15:11] == 5'b00100) begin
      dec_ok     = 1'b1;
      dec_rd     = inst[10:8];
      dec_imm    = inst[7:0];
      dec_rm_imm = 1'b1;
    end else if (inst[15:10] == 6'b010000) begin
      dec_ra      = inst[2:0];
      dec_rb      = inst[5:3];
      dec_rd      = inst[2:0];
      dec_op2_reg = 1'b1;
      unique case (inst[9:6])
        4'b0010: begin dec_ok = 1'b1; dec_stype = 2'b00; end
        4'b0011: begin dec_ok = 1'b1; dec_stype = 2'b01; end
        4'b0100: begin dec_ok = 1'b1; dec_stype = 2'b10; end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  assign inst_ready = (state_q == StIdle);
  assign accept     = inst_valid && inst_ready;

  // Next-state logic for the issue sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && dec_ok) begin
          state_d = StRead;
          cnt_d   = 2'd0;
        end
      end
      StRead: begin
        if (cnt_q == 2'(RF_RD_LAT - 1)) begin
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StLatch: state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture decoded fields on accept; undef pulses the cycle after a bad word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stype_q   <= 2'b00;
      imm_q     <= 8'h00;
      rd_q      <= 3'd0;
      ra_q      <= 3'd0;
      rb_q      <= 3'd0;
      rm_imm_q  <= 1'b0;
      op2_reg_q <= 1'b0;
      undef_q   <= 1'b0;
    end else begin
      undef_q <= accept && !dec_ok;
      if (accept && dec_ok) begin
        stype_q   <= dec_stype;
        imm_q     <= dec_imm;
        rd_q      <= dec_rd;
        ra_q      <= dec_ra;
        rb_q      <= dec_rb;
        rm_imm_q  <= dec_rm_imm;
        op2_reg_q <= dec_op2_reg;
      end
    end
  end

  // Execute-unit operands update only when leaving LATCH, so they stay stable
  // around the en_inst edge and through writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rm_q        <= 32'h0;
      op2_q       <= 8'h00;
      stype_out_q <= 2'b00;
      s_q         <= 1'b0;
      wb_addr_q   <= 3'd0;
    end else if (state_q == StLatch) begin
      rm_q        <= rm_imm_q ? {24'h0, imm_q} : rf_rdata_a;
      op2_q       <= rm_imm_q ? 8'h00 : (op2_reg_q ? rf_rdata_b[7:0] : imm_q);
      stype_out_q <= stype_q;
      s_q         <= 1'b1;
      wb_addr_q   <= rd_q;
    end
  end

  assign rf_raddr_a = ra_q;
  assign rf_raddr_b = rb_q;
  assign en_inst    = (state_q == StExec);
  assign wb_we      = (state_q == StWb);
  assign Rm         = rm_q;
  assign operand2   = op2_q;
  assign stype      = stype_out_q;
  assign S          = s_q;
  assign wb_addr    = wb_addr_q;
  assign undef      = undef_q;

endmodule
